prog_loader: RTL and testbench

Byte-stream program loader that sits directly upstream of the tiny CPU's 16×8 instruction ROM. It accepts program bytes over a valid/ready handshake, writes them sequentially into the ROM write port at addresses 0..15, and holds the CPU in reset until the image is complete. It then releases the CPU and reports completion or error.

---
 rtl/prog_loader.sv | 161 ++++++++++++++++
 tb/tb_prog_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream loader that fills the CPU instruction ROM and holds the CPU in reset until the image is complete
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : each image is DEPTH payload bytes plus one two's-complement checksum byte,
//               checked in a CHK state; err reports a checksum failure (sticky until start)
//   undefined : no CHK state or accumulator; LOAD goes straight to SETTLE; err tied to 0
//
// Ports:
//   clk, rst            - system clock (rising edge), asynchronous active-high reset
//   start               - one-cycle load request, honoured only in IDLE and RUN
//   in_data/in_valid    - program byte stream input
//   in_ready            - high in LOAD (and CHK) only
//   wr_en/wr_addr/wr_data - registered ROM write port, one strobe per accepted payload byte
//   cpu_rst             - active-high CPU reset, low only in RUN
//   done                - high only in RUN
//   err                 - checksum failure of the last load
module prog_loader #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          cpu_rst,
    output logic          done,
    output logic          err
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_SETTLE,
        S_RUN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic          load_start;
    logic          xfer;

    // start is only honoured from IDLE or RUN; in LOAD/CHK/SETTLE it is dropped
    assign load_start = start && ((state == S_IDLE) || (state == S_RUN));

`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0] acc;
    logic [DW-1:0] chk_sum;
    logic          chk_ok;

    assign in_ready = (state == S_LOAD) || (state == S_CHK);
    assign chk_sum  = acc + in_data;
    assign chk_ok   = (chk_sum == '0);
`else
    assign in_ready = (state == S_LOAD);
`endif

    assign xfer = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cpu_rst   = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (xfer && (cnt == LAST_IDX)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = S_CHK;
`else
                    state_nxt = S_SETTLE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                // a bad image leaves the CPU held in reset
                if (xfer) begin
                    state_nxt = chk_ok ? S_SETTLE : S_IDLE;
                end
            end
`endif
            // one extra cycle so the final ROM write commits before the CPU's first edge
            S_SETTLE: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ROM write port and byte counter; the counter is cleared on every entry to LOAD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            cnt     <= '0;
        end else begin
            wr_en <= 1'b0;
            if (load_start) begin
                cnt <= '0;
            end else if ((state == S_LOAD) && xfer) begin
                wr_en   <= 1'b1;
                wr_addr <= cnt;
                wr_data <= in_data;
                cnt     <= cnt + 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            err <= 1'b0;
        end else if (load_start) begin
            acc <= '0;
            err <= 1'b0;
        end else if ((state == S_LOAD) && xfer) begin
            acc <= acc + in_data;
        end else if ((state == S_CHK) && xfer && !chk_ok) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader with a ROM-write scoreboard
module tb_prog_loader;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          cpu_rst;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    prog_loader #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  next_addr  = 0;
    int  streak     = 0;
    int  max_streak = 0;

    typedef struct {
        string      name;
        logic [7:0] base;
        logic [7:0] step;
        int         gap;
        int         poke;
        logic       chk_good;
        logic [7:0] chk;
        logic       exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard: every ROM write must match the oldest expected write
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                streak++;
                if (streak > max_streak) max_streak = streak;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: addr %0d data 0x%0h, no write expected", wr_addr, wr_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                end
            end else begin
                streak = 0;
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        next_addr = 0;
    endtask

    // drives one byte after 'gap' idle cycles; returns just after the accepting edge
    task automatic send(input logic [7:0] d, input int gap, input bit payload);
        bit acc;
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
        end
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 100) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            acc      = in_ready;
            @(posedge clk);
            t++;
        end
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: byte 0x%0h not accepted within 100 cycles", d);
        end else if (payload) begin
            exp_q.push_back('{addr: AW'(next_addr), data: d});
            next_addr++;
        end
    endtask

    task automatic pulse_start_idle_valid();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic load_image(input vec_t v);
        logic [7:0] sum;
        logic [7:0] d;
        logic [7:0] cb;
        logic       ee;
        ee         = CHK_ON ? v.exp_err : 1'b0;
        max_streak = 0;
        do_start();
        check({v.name, "_ready_after_start"}, 32'(in_ready), 32'd1);
        check({v.name, "_err_cleared"}, 32'(err), 32'd0);
        check({v.name, "_cpu_rst_loading"}, 32'(cpu_rst), 32'd1);
        sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == v.poke) pulse_start_idle_valid();
            d   = v.base + 8'(i) * v.step;
            sum = sum + d;
            send(d, v.gap, 1'b1);
        end
        if (CHK_ON) begin
            cb = v.chk_good ? 8'(8'd0 - sum) : v.chk;
            send(cb, v.gap, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check({v.name, "_ready_after_last"}, 32'(in_ready), 32'd0);
        check({v.name, "_done_settle"}, 32'(done), 32'd0);
        check({v.name, "_cpu_rst_settle"}, 32'(cpu_rst), 32'd1);
        check({v.name, "_err"}, 32'(err), 32'(ee));
        @(negedge clk);
        check({v.name, "_done_run"}, 32'(done), 32'(!ee));
        check({v.name, "_cpu_rst_run"}, 32'(cpu_rst), 32'(ee));
        check({v.name, "_ready_run"}, 32'(in_ready), 32'd0);
        check({v.name, "_err_hold"}, 32'(err), 32'(ee));
        check({v.name, "_all_writes_seen"}, 32'(exp_q.size()), 32'd0);
        if (v.gap == 0 && v.poke < 0) check({v.name, "_wr_streak"}, 32'(max_streak), 32'd16);
        else if (v.gap > 0)           check({v.name, "_wr_streak"}, 32'(max_streak), 32'd1);
    endtask

    initial begin
        vecs[0] = '{"stream",    8'h10, 8'h01, 0, -1, 1'b1, 8'h00, 1'b0};
        vecs[1] = '{"toggle",    8'h10, 8'h01, 1, -1, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{"mixed",     8'hA5, 8'h3B, 2, -1, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{"chk_ok",    8'h01, 8'h00, 0, -1, 1'b0, 8'hF0, 1'b0};
        vecs[4] = '{"chk_bad",   8'h01, 8'h00, 0, -1, 1'b0, 8'hEF, 1'b1};
        vecs[5] = '{"mid_start", 8'h20, 8'h03, 0,  5, 1'b1, 8'h00, 1'b0};

        // reset only: outputs must hold their reset values with no start
        #1 rst = 1'b1;
        #1;
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("idle_cpu_rst", 32'(cpu_rst), 32'd1);
            check("idle_done", 32'(done), 32'd0);
            check("idle_in_ready", 32'(in_ready), 32'd0);
        end

        foreach (vecs[i]) load_image(vecs[i]);

        // reset mid-load: counter must restart at address 0
        do_start();
        for (int i = 0; i < 7; i++) send(8'h40 + 8'(i), 0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_still_idle", 32'(in_ready), 32'd0);
        load_image('{"after_rst", 8'h10, 8'h01, 0, -1, 1'b1, 8'h00, 1'b0});

        // start in RUN: CPU reset reasserts at the sampling edge and reload begins at address 0
        check("run_done_before", 32'(done), 32'd1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        check("restart_in_ready", 32'(in_ready), 32'd1);
        load_image('{"reload", 8'hC0, 8'h05, 0, -1, 1'b1, 8'h00, 1'b0});

        repeat (3) @(negedge clk);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
